// File: rtl/md_sequencer_if.sv
// EX-stage multiply/divide bus: decode-side operands and controls, HI/LO results and stall.
interface md_sequencer_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDop;
  logic        start;
  logic        rd_hi;
  logic        md_use_D;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDout;

  modport master (
    output A, B, MDop, start, rd_hi, md_use_D,
    input  busy, stall_req, HI, LO, MDout
  );

  modport slave (
    input  A, B, MDop, start, rd_hi, md_use_D,
    output busy, stall_req, HI, LO, MDout
  );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer holding HI/LO beside the EX-stage ALU.
// Operands are latched on accept; the result is computed from the latches on the final RUN edge.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [2:0]        r_op;
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;

  logic w_is_md;
  logic w_is_mt;
  logic w_last;
  logic w_busy;
  logic w_load;
  logic w_done;
  logic w_mt_wr;

  assign w_is_md = (md.MDop >= OP_MULT) && (md.MDop <= OP_DIVU);
  assign w_is_mt = (md.MDop == OP_MTHI) || (md.MDop == OP_MTLO);
  assign w_last  = (r_cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (md.start && w_is_md) w_state_nxt = S_RUN;
      S_RUN:  if (w_last)              w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy  = 1'b0;
    w_load  = 1'b0;
    w_done  = 1'b0;
    w_mt_wr = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load  = md.start && w_is_md;
        w_mt_wr = md.start && w_is_mt;
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_done = w_last;
      end
      default: ;
    endcase
  end

  // Multiply: sign- or zero-extend to 64 bits so the low 64 product bits are exact.
  logic [63:0] w_a_sx, w_b_sx, w_prod_s, w_prod_u;
  assign w_a_sx   = {{32{r_a[31]}}, r_a};
  assign w_b_sx   = {{32{r_b[31]}}, r_b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Divide: one unsigned divider on magnitudes, signs restored afterwards.
  logic        w_signed_div;
  logic [31:0] w_a_mag, w_b_mag, w_dvd, w_dvs, w_q, w_r, w_q_fix, w_r_fix;
  assign w_signed_div = (r_op == OP_DIV);
  assign w_a_mag = r_a[31] ? -r_a : r_a;
  assign w_b_mag = r_b[31] ? -r_b : r_b;
  assign w_dvd   = w_signed_div ? w_a_mag : r_a;
  assign w_dvs   = w_signed_div ? w_b_mag : r_b;
  assign w_q     = (w_dvs == 32'd0) ? 32'd0 : w_dvd / w_dvs;
  assign w_r     = (w_dvs == 32'd0) ? 32'd0 : w_dvd % w_dvs;
  assign w_q_fix = (w_signed_div && (r_a[31] ^ r_b[31])) ? -w_q : w_q;
  assign w_r_fix = (w_signed_div && r_a[31]) ? -w_r : w_r;

  logic        w_res_wr;
  logic [31:0] w_res_hi, w_res_lo;

  always_comb begin
    w_res_wr = 1'b0;
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (r_op)
      OP_MULT:  begin w_res_wr = 1'b1; w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
      OP_MULTU: begin w_res_wr = 1'b1; w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
      OP_DIV,
      OP_DIVU:  begin w_res_wr = (r_b != 32'd0); w_res_hi = w_r_fix; w_res_lo = w_q_fix; end
      default: ;
    endcase
  end

  // Operand latches, latency counter and HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_load) begin
        r_a   <= md.A;
        r_b   <= md.B;
        r_op  <= md.MDop;
        r_cnt <= (md.MDop <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (w_busy) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_done && w_res_wr) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_mt_wr) begin
        if (md.MDop == OP_MTHI) r_hi <= md.A;
        else                    r_lo <= md.A;
      end
    end
  end

  assign md.busy      = w_busy;
  assign md.HI        = r_hi;
  assign md.LO        = r_lo;
  assign md.MDout     = md.rd_hi ? r_hi : r_lo;
  // Start term covers the accept cycle before busy rises.
  assign md.stall_req = md.md_use_D && (w_busy || (md.start && w_is_md));

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: an edge-indexed HI/LO model checked every cycle
// plus literal expectations for the key results and latencies.
module tb_md_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_sequencer_if mdi();

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdi)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one mult/div operation.
  function automatic void model_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic wr, output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    wr = 1'b1; hi = '0; lo = '0;
    case (op)
      3'd1: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      3'd2: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      3'd3: if (b == 0) wr = 1'b0; else begin sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0]; end
      default: if (b == 0) wr = 1'b0; else begin hi = a % b; lo = a / b; end
    endcase
  endfunction

  // Model: n counts edges; an op accepted at edge n completes at edge m_end = n + latency.
  int          n = 0;
  int          m_end = -1;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        p_wr = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_end = -1;
      m_hi  = '0;
      m_lo  = '0;
    end else begin
      n++;
      if (n == m_end && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      if (n > m_end && mdi.start) begin
        if (mdi.MDop inside {[3'd1:3'd4]}) begin
          model_calc(mdi.MDop, mdi.A, mdi.B, p_wr, p_hi, p_lo);
          m_end = n + ((mdi.MDop <= 3'd2) ? 5 : 10);
        end else if (mdi.MDop == 3'd5) begin
          m_hi = mdi.A;
        end else if (mdi.MDop == 3'd6) begin
          m_lo = mdi.A;
        end
      end
    end
  end

  logic exp_busy, exp_stall;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_busy  = reset && (n < m_end);
      exp_stall = mdi.md_use_D && (exp_busy || (mdi.start && (mdi.MDop inside {[3'd1:3'd4]})));
      check("busy",      32'(mdi.busy),      32'(exp_busy));
      check("stall_req", 32'(mdi.stall_req), 32'(exp_stall));
      check("HI",        mdi.HI,             m_hi);
      check("LO",        mdi.LO,             m_lo);
      check("MDout",     mdi.MDout,          mdi.rd_hi ? m_hi : m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mdi.A = a; mdi.B = b; mdi.MDop = op; mdi.start = 1'b1;
    tick();
    mdi.start = 1'b0; mdi.MDop = 3'd0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (mdi.busy && cyc < 100) begin
      cyc++;
      tick();
    end
    if (cyc >= 100) begin
      errors++;
      $display("FAIL wait_idle: busy stuck high after %0d cycles", cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int sc;
    mdi.A = '0; mdi.B = '0; mdi.MDop = '0; mdi.start = 1'b0; mdi.rd_hi = 1'b0; mdi.md_use_D = 1'b0;
    repeat (2) tick();
    chk_en = 1'b1;
    check("reset busy", 32'(mdi.busy), 32'd0);
    check("reset HI", mdi.HI, 32'd0);
    check("reset LO", mdi.LO, 32'd0);
    reset = 1'b1;
    tick();

    // Reset mid-operation discards the in-flight mult and clears HI/LO.
    issue(3'd5, 32'h99, 0);
    issue(3'd1, 32'd3, 32'd4);
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    check("rst_mid busy", 32'(mdi.busy), 32'd0);
    check("rst_mid HI", mdi.HI, 32'd0);
    check("rst_mid LO", mdi.LO, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (8) tick();
    check("rst_late HI", mdi.HI, 32'd0);
    check("rst_late LO", mdi.LO, 32'd0);

    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(c);
    check("mult cycles", 32'(c), 32'd5);
    check("mult HI", mdi.HI, 32'hFFFF_FFFF);
    check("mult LO", mdi.LO, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFFE, 32'd3);
    wait_idle(c);
    check("multu cycles", 32'(c), 32'd5);
    check("multu HI", mdi.HI, 32'h0000_0002);
    check("multu LO", mdi.LO, 32'hFFFF_FFFA);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(c);
    check("div cycles", 32'(c), 32'd10);
    check("div HI", mdi.HI, 32'hFFFF_FFFF);
    check("div LO", mdi.LO, 32'hFFFF_FFFD);

    issue(3'd4, 32'd100, 32'd7);
    wait_idle(c);
    check("divu HI", mdi.HI, 32'd2);
    check("divu LO", mdi.LO, 32'd14);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(c);
    check("div ovf HI", mdi.HI, 32'd0);
    check("div ovf LO", mdi.LO, 32'h8000_0000);

    issue(3'd5, 32'h11, 0);
    issue(3'd6, 32'h22, 0);
    issue(3'd3, 32'd5, 32'd0);
    wait_idle(c);
    check("div0 cycles", 32'(c), 32'd10);
    check("div0 HI", mdi.HI, 32'h11);
    check("div0 LO", mdi.LO, 32'h22);

    // Stall window: accept cycle plus every busy cycle.
    mdi.md_use_D = 1'b1;
    mdi.A = 32'd9; mdi.B = 32'd4; mdi.MDop = 3'd3; mdi.start = 1'b1;
    #1;
    sc = (mdi.stall_req === 1'b1) ? 1 : 0;
    tick();
    mdi.start = 1'b0; mdi.MDop = 3'd0;
    c = 0;
    while (mdi.busy && c < 100) begin
      if (mdi.stall_req === 1'b1) sc++;
      c++;
      tick();
    end
    check("stall cycles", 32'(sc), 32'd11);
    check("stall after", 32'(mdi.stall_req), 32'd0);
    mdi.md_use_D = 1'b0;
    issue(3'd3, 32'd9, 32'd4);
    sc = 0; c = 0;
    while (mdi.busy && c < 100) begin
      if (mdi.stall_req !== 1'b0) sc++;
      c++;
      tick();
    end
    check("no-use stall", 32'(sc), 32'd0);

    // Start while busy is ignored; operand changes during RUN have no effect.
    issue(3'd1, 32'd2, 32'd3);
    tick();
    issue(3'd6, 32'h55, 32'd9);
    mdi.A = 32'd7; mdi.B = 32'd8;
    wait_idle(c);
    check("ignore LO", mdi.LO, 32'd6);
    check("ignore HI", mdi.HI, 32'd0);

    mdi.rd_hi = 1'b1;
    issue(3'd5, 32'hDEAD_BEEF, 0);
    check("mthi MDout", mdi.MDout, 32'hDEAD_BEEF);
    check("mthi busy", 32'(mdi.busy), 32'd0);

    // Back-to-back: second op accepted on the first idle cycle.
    issue(3'd1, 32'h10, 32'h10);
    wait_idle(c);
    check("b2b mult HI", mdi.HI, 32'd0);
    check("b2b mult LO", mdi.LO, 32'h100);
    check("b2b gap busy", 32'(mdi.busy), 32'd0);
    issue(3'd4, 32'd100, 32'd7);
    check("b2b accepted", 32'(mdi.busy), 32'd1);
    wait_idle(c);
    check("b2b divu cycles", 32'(c), 32'd10);
    check("b2b MDout HI", mdi.MDout, 32'd2);
    mdi.rd_hi = 1'b0;
    #1;
    check("b2b MDout LO", mdi.MDout, 32'd14);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
